// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save datapath: resolver FSM states and
// the digit-count helper used to size the iterative carry-propagate path.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resolve_state_t;

    // Digits needed to cover a WIDTH+1 bit operand (the shifted carry vector adds one bit).
    function automatic int num_digits(input int width, input int digit);
        return (width + 1 + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/csa_resolve_chk.sv
// Property checker for the resolver: the top padded digit can never carry out,
// because S + 2*C always fits in WIDTH+2 bits.
module csa_resolve_chk (
    input logic clk,
    input logic reset,
    input logic i_last,
    input logic i_cy
);

    a_no_final_carry: assert property (@(posedge clk) disable iff (reset) i_last |-> !i_cy)
        else $error("final digit produced a carry out");

endmodule

// File: rtl/csa_resolve_cpa_digit.sv
// One DIGIT-bit carry-propagate adder slice with carry-in and carry-out;
// the resolver reuses this single slice every cycle.
module cpa_digit #(
    parameter int DIGIT = 64
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/csa_resolve.sv
// Carry-save to binary resolver: returns S + 2*C, resolving DIGIT bits per
// cycle through one shared carry-propagate slice.
module csa_resolve
    import csa_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int DIGIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_sum
);

    localparam int NDIG  = num_digits(WIDTH, DIGIT);
    localparam int PADW  = NDIG * DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_width_check
        $error("csa_resolve: WIDTH must be a multiple of DIGIT");
    end

    resolve_state_t    r_state;
    resolve_state_t    w_state_nxt;
    logic [PADW-1:0]   r_a;
    logic [PADW-1:0]   r_b;
    logic [PADW-1:0]   r_res;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH+1:0]  r_out_sum;
    logic              r_out_valid;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_out_hs;
    logic              w_last;
    logic              w_load_out;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;
    logic [DIGIT-1:0]  w_d;
    logic              w_cy;

    assign w_accept = in_valid && r_in_ready;
    assign w_out_hs = r_out_valid && out_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(NDIG - 1));

    cpa_digit #(.DIGIT(DIGIT)) u_cpa (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_d),
        .o_cout (w_cy)
    );

    csa_resolve_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .i_last (w_last),
        .i_cy   (w_cy)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (w_out_hs) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode; the result is published one cycle after entering DONE
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_load_out      = 1'b0;
        case (r_state)
            DONE: begin
                w_out_valid_nxt = !w_out_hs;
                w_load_out      = !r_out_valid;
                w_in_ready_nxt  = w_out_hs;
            end
            IDLE: begin
                w_in_ready_nxt = !w_accept;
            end
            RUN: begin
                w_in_ready_nxt = 1'b0;
            end
            default: begin
                w_in_ready_nxt = 1'b1;
            end
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Operand shift registers, digit counter, carry and result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= {PADW{1'b0}};
            r_b       <= {PADW{1'b0}};
            r_res     <= {PADW{1'b0}};
            r_carry   <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_out_sum <= {(WIDTH+2){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= PADW'({1'b0, in_s});
                        r_b     <= PADW'({in_c, 1'b0});
                        r_carry <= 1'b0;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    // Low digit is consumed; its sum enters the result from the top
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= {w_d, r_res[PADW-1:DIGIT]};
                    r_carry <= w_cy;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    if (w_load_out) begin
                        r_out_sum <= r_res[WIDTH+1:0];
                    end
                end
                default: begin
                    r_carry <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_csa_resolve.sv
// Self-checking bench for csa_resolve: directed corner operands plus random
// pairs, all compared against the arithmetic value S + 2*C.
module tb_csa_resolve;

    localparam int W   = 1024;
    localparam int LAT = 18;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_c;
    logic [W-1:0]   in_s;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   out_sum;

    int n_checks;
    int n_pass;

    csa_resolve #(.WIDTH(W), .DIGIT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        return {2'b00, s} + {1'b0, c, 1'b0};
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 5))
            0: v = {W{1'b1}};
            1: v = {W{1'b0}};
            2: v = v | {{(W/2){1'b0}}, {(W/2){1'b1}}};
            default: ;
        endcase
        return v;
    endfunction

    // Offer one pair, wait for the result, take it. Latency counted in edges after accept.
    task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c,
                         output logic [W+1:0] got, output int lat, output bit timeout);
        int k;
        timeout = 1'b0;
        lat = 0;
        got = '0;
        in_s = s;
        in_c = c;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        got = out_sum;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0)
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_sum_nonzero=%b, required 1/0/0",
                     in_ready, out_valid, |out_sum);
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] s_tab [4];
        logic [W-1:0] c_tab [4];
        logic [W+1:0] got;
        logic [W+1:0] exp;
        int lat;
        bit to;
        s_tab[0] = {W{1'b1}};               c_tab[0] = '0;
        s_tab[1] = '0;                      c_tab[1] = {W{1'b1}};
        s_tab[2] = {W{1'b1}};               c_tab[2] = {W{1'b1}};
        s_tab[3] = {{(W-64){1'b0}}, {64{1'b1}}}; c_tab[3] = {{(W-1){1'b0}}, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(s_tab[i], c_tab[i], got, lat, to);
            exp = model(s_tab[i], c_tab[i]);
            n_checks++;
            if (to) $display("FAIL directed_%0d_timeout: no result, required result within 100 cycles", i);
            else if (got !== exp)
                $display("FAIL directed_%0d_sum: got top=%h low=%h, required top=%h low=%h",
                         i, got[W+1:W-32], got[31:0], exp[W+1:W-32], exp[31:0]);
            else n_pass++;
            n_checks++;
            if (lat != LAT) $display("FAIL directed_%0d_latency: got %0d, required %0d", i, lat, LAT);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL directed_%0d_post_hs: out_valid=%b in_ready=%b, required 0/1",
                         i, out_valid, in_ready);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (got[W+1:W] !== 2'b10 || got[7:0] !== 8'hFD)
                    $display("FAIL directed_both_ones_bits: top=%b low8=%h, required 10/fd",
                             got[W+1:W], got[7:0]);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (got[64] !== 1'b1 || got[63:0] !== 64'd1)
                    $display("FAIL directed_digit_cross: bit64=%b low=%h, required 1/1", got[64], got[63:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        int lat;
        bit to;
        for (int i = 0; i < 20; i++) begin
            s = rand_vec();
            c = rand_vec();
            exp = model(s, c);
            do_op(s, c, got, lat, to);
            n_checks++;
            if (to || got !== exp || lat != LAT)
                $display("FAIL random_%0d: timeout=%b lat=%0d got_low=%h got_top=%h, required lat=%0d low=%h top=%h",
                         i, to, lat, got[31:0], got[W+1:W-32], LAT, exp[31:0], exp[W+1:W-32]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W+1:0] exp;
        int k;
        s = rand_vec();
        c = rand_vec();
        exp = model(s, c);
        in_s = s; in_c = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1; k++;
        end
        n_checks++;
        if (!out_valid) $display("FAIL stall_timeout: out_valid=0, required 1 within 100 cycles");
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_s = ~s; in_c = ~c; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp)
                $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b sum_ok=%b, required 1/0/1",
                         i, out_valid, in_ready, out_sum === exp);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_pulse_ignored: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        int lat;
        bit to;
        in_s = rand_vec(); in_c = rand_vec(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0)
            $display("FAIL reset_mid_run: in_ready=%b out_valid=%b sum_nonzero=%b, required 1/0/0",
                     in_ready, out_valid, |out_sum);
        else n_pass++;
        s = rand_vec();
        c = rand_vec();
        exp = model(s, c);
        do_op(s, c, got, lat, to);
        n_checks++;
        if (to || got !== exp || lat != LAT)
            $display("FAIL reset_next_op: timeout=%b lat=%0d got_low=%h, required lat=%0d low=%h",
                     to, lat, got[31:0], LAT, exp[31:0]);
        else n_pass++;
    endtask

    task automatic test_idle_out_ready();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL idle_out_ready: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_c      = '0;
        in_s      = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_idle_out_ready();
        test_random();
        test_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
